// File: rtl/sto_pkg.sv
// sto_pkg: shared constants, FSM state type and LFSR helper
// for the STO estimator.
package sto_pkg;

  localparam int SAMPLE_W = 8;
  localparam int CFG_W    = 12;
  localparam int METRIC_W = 21;

  // Fibonacci taps x^16+x^14+x^13+x^11+1 on a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [CFG_W-1:0] ERR_STO = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    CP,
    INIT,
    SLIDE,
    DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sto_lfsr_src.sv
// sto_lfsr_src: 16-bit Fibonacci LFSR test-sample source
// with seed reload and step control.
module sto_lfsr_src
  import sto_pkg::*;
#(
  parameter int          SW   = SAMPLE_W,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  output logic signed [SW-1:0] sample
);

  logic [15:0] lfsr;

  // seed on reset/load, advance one step per generated sample
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign sample = lfsr[SW-1:0];

endmodule

// File: rtl/sto_estimator.sv
// sto_estimator: builds a two-symbol CP-OFDM-like test stream
// and finds the STO by a cyclic-prefix minimum-difference search.
module sto_estimator
  import sto_pkg::*;
#(
  parameter int          SW        = SAMPLE_W,
  parameter int          BUF_DEPTH = 1024,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [CFG_W-1:0] com_delay,
  input  logic [CFG_W-1:0] Ng,
  input  logic [CFG_W-1:0] Nfft,
  output logic [CFG_W-1:0] est_STO,
  output logic             done
);

  // one extra bit so Ng+Nfft and index sums never wrap
  localparam int IW = CFG_W + 1;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [IW:0] BUF_LIM = (IW+1)'(BUF_DEPTH);

  state_t state;

  logic [IW-1:0] d_r;
  logic [IW-1:0] ng_r;
  logic [IW-1:0] nfft_r;
  logic [IW-1:0] ns_r;
  logic [IW-1:0] cnt;
  logic          cfg_err;

  logic [METRIC_W-1:0] m;
  logic [METRIC_W-1:0] m_next;
  logic [METRIC_W-1:0] best;
  logic [CFG_W-1:0]    best_n;

  logic [SW-1:0] ram [BUF_DEPTH];

  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] rc;
  logic [AW-1:0] rd;
  logic [AW-1:0] wa;
  logic [SW-1:0] wd;
  logic          we;

  logic [SW-1:0] ra_q;
  logic [SW-1:0] rb_q;
  logic [SW-1:0] rc_q;
  logic [SW-1:0] rd_q;
  logic [SW:0]   ad_add;
  logic [SW:0]   ad_sub;

  logic [SW-1:0] sample;
  logic          accept;

  logic [IW-1:0] ns_c;
  logic          cfg_bad;

  function automatic logic [SW:0] abs_diff(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic signed [SW:0] df;
    df = $signed({a[SW-1], a}) - $signed({b[SW-1], b});
    return df[SW] ? (~df + (SW+1)'(1)) : df;
  endfunction

  assign accept = (state == IDLE) && go;

  assign ns_c = IW'(Ng) + IW'(Nfft);
  assign cfg_bad = (Ng == '0)
                || (Ng > Nfft)
                || (IW'(com_delay) >= ns_c)
                || ({ns_c, 1'b0} > BUF_LIM);

  sto_lfsr_src #(
    .SW   (SW),
    .SEED (SEED)
  ) u_src (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state == GEN),
    .sample (sample)
  );

  // read addresses: CP source, or the add/drop window pairs
  always_comb begin
    ra = AW'(cnt);
    rb = AW'(cnt + nfft_r);
    rc = AW'(cnt - IW'(1));
    rd = AW'(cnt - IW'(1) + nfft_r);
    if (state == CP) begin
      ra = AW'(d_r + nfft_r + cnt);
    end else if (state == SLIDE) begin
      ra = AW'(cnt + ng_r - IW'(1));
      rb = AW'(cnt + ng_r - IW'(1) + nfft_r);
    end
  end

  assign ra_q = ram[ra];
  assign rb_q = ram[rb];
  assign rc_q = ram[rc];
  assign rd_q = ram[rd];

  assign ad_add = abs_diff(ra_q, rb_q);
  assign ad_sub = abs_diff(rc_q, rd_q);

  // running metric: INIT only adds, SLIDE adds the new pair and drops the old
  always_comb begin
    m_next = m + METRIC_W'(ad_add);
    if (state == SLIDE) begin
      m_next = m_next - METRIC_W'(ad_sub);
    end
  end

  // buffer write port: random fill in GEN, prefix copy in CP
  always_comb begin
    we = 1'b0;
    wa = AW'(cnt);
    wd = sample;
    unique case (state)
      GEN: we = 1'b1;
      CP: begin
        we = 1'b1;
        wa = AW'(d_r + cnt);
        wd = ra_q;
      end
      default: we = 1'b0;
    endcase
  end

  // sample buffer storage, contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      ram[wa] <= wd;
    end
  end

  // control FSM with registered result and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      est_STO <= '0;
      done    <= 1'b0;
      m       <= '0;
      best    <= '0;
      best_n  <= '0;
      cnt     <= '0;
      cfg_err <= 1'b0;
      d_r     <= '0;
      ng_r    <= '0;
      nfft_r  <= '0;
      ns_r    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            d_r     <= IW'(com_delay);
            ng_r    <= IW'(Ng);
            nfft_r  <= IW'(Nfft);
            ns_r    <= ns_c;
            cnt     <= '0;
            m       <= '0;
            cfg_err <= cfg_bad;
            state   <= cfg_bad ? DONE : GEN;
          end
        end
        GEN: begin
          if (cnt == {ns_r[IW-2:0], 1'b0} - IW'(1)) begin
            cnt   <= '0;
            state <= CP;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        CP: begin
          if (cnt == ng_r - IW'(1)) begin
            cnt   <= '0;
            state <= INIT;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        INIT: begin
          m <= m_next;
          if (cnt == ng_r - IW'(1)) begin
            best   <= m_next;
            best_n <= '0;
            cnt    <= IW'(1);
            state  <= SLIDE;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        SLIDE: begin
          m <= m_next;
          if (m_next < best) begin
            best   <= m_next;
            best_n <= cnt[CFG_W-1:0];
          end
          if (cnt == ns_r - IW'(1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        DONE: begin
          est_STO <= cfg_err ? ERR_STO : best_n;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sto_estimator.sv
// tb_sto_estimator: directed table, corner sequences and
// randomized runs against a brute-force STO model.
module tb_sto_estimator;
  import sto_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [11:0] com_delay;
  logic [11:0] Ng;
  logic [11:0] Nfft;
  logic [11:0] est_STO;
  logic        done;

  int checks = 0;
  int errors = 0;

  sto_estimator dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .com_delay (com_delay),
    .Ng        (Ng),
    .Nfft      (Nfft),
    .est_STO   (est_STO),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int ng;
    int nfft;
    int exp_sto;
    int exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit cfg_ok(input int d, input int ng, input int nfft);
    int ns;
    ns = ng + nfft;
    return (ng != 0) && (ng <= nfft) && (d < ns) && (2 * ns <= 1024);
  endfunction

  // builds the stream from the rules and scans every window start
  function automatic int model(input int d, input int ng, input int nfft);
    int r [0:1023];
    logic [15:0] l;
    int ns, m, best, bn, x;
    if (!cfg_ok(d, ng, nfft)) return 'hFFF;
    ns = ng + nfft;
    l = 16'hACE1;
    for (int k = 0; k < 2 * ns; k++) begin
      r[k] = $signed(l[7:0]);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    for (int j = 0; j < ng; j++) r[d + j] = r[d + nfft + j];
    best = 0;
    bn = 0;
    for (int n = 0; n < ns; n++) begin
      m = 0;
      for (int i = 0; i < ng; i++) begin
        x = r[n + i] - r[n + i + nfft];
        m += (x < 0) ? -x : x;
      end
      if (n == 0 || m < best) begin
        best = m;
        bn = n;
      end
    end
    return bn;
  endfunction

  task automatic run(input int d, input int ng, input int nfft,
                     input int exp_sto, input int exp_lat,
                     input string nm);
    int cyc;
    bit seen;
    com_delay = 12'(d);
    Ng = 12'(ng);
    Nfft = 12'(nfft);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, cyc, exp_lat);
    chk({nm, "_est"}, est_STO, exp_sto);
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  initial begin
    vec_t tbl [];
    int ndone, first, second, stable;
    int d, ng, nfft, ns, e, lat;

    tbl = new[10];
    tbl[0] = '{32, 32, 128, 32, 544};
    tbl[1] = '{0, 16, 64, 0, 272};
    tbl[2] = '{79, 16, 64, 79, 272};
    tbl[3] = '{5, 16, 64, 5, 272};
    tbl[4] = '{160, 32, 128, 'hFFF, 1};
    tbl[5] = '{0, 0, 64, 'hFFF, 1};
    tbl[6] = '{0, 20, 16, 'hFFF, 1};
    tbl[7] = '{0, 100, 500, 'hFFF, 1};
    tbl[8] = '{3, 12, 500, 3, 1560};
    tbl[9] = '{511, 12, 500, 511, 1560};

    reset = 1'b1;
    go = 1'b0;
    com_delay = '0;
    Ng = '0;
    Nfft = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_est", est_STO, 0);
    chk("reset_done", done, 0);

    foreach (tbl[i]) begin
      run(tbl[i].d, tbl[i].ng, tbl[i].nfft, tbl[i].exp_sto,
          tbl[i].exp_lat, $sformatf("tbl%0d", i));
    end

    // result holds with no further pulses
    run(32, 32, 128, 32, 544, "hold_run");
    ndone = 0;
    stable = 1;
    repeat (4500) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (est_STO !== 12'd32) stable = 0;
    end
    chk("hold_no_done", ndone, 0);
    chk("hold_est_stable", stable, 1);

    // go pulses during GEN and SLIDE are ignored
    com_delay = 12'd32;
    Ng = 12'd32;
    Nfft = 12'd128;
    go = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 600; c++) begin
      go = (c == 10 || c == 450);
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    go = 1'b0;
    chk("ignore_go_count", ndone, 1);
    chk("ignore_go_latency", first, 544);
    chk("ignore_go_est", est_STO, 32);

    // go held high: back-to-back runs, new run the cycle after DONE
    com_delay = 12'd7;
    Ng = 12'd16;
    Nfft = 12'd64;
    go = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    first = 0;
    second = 0;
    for (int c = 1; c <= 600; c++) begin
      if (c == 300) go = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    chk("held_go_count", ndone, 2);
    chk("held_go_first", first, 272);
    chk("held_go_second", second, 545);
    chk("held_go_est", est_STO, 7);

    // reset in SLIDE aborts the run
    com_delay = 12'd40;
    Ng = 12'd32;
    Nfft = 12'd128;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (450) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_est", est_STO, 0);
    chk("midreset_done", done, 0);
    chk("midreset_idle", dut.state == IDLE, 1);
    ndone = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    run(5, 16, 64, 5, 272, "after_reset");

    // randomized configurations against the model
    for (int t = 0; t < 20; t++) begin
      nfft = $urandom_range(4, 120);
      ng = $urandom_range(0, nfft + 2);
      ns = ng + nfft;
      d = $urandom_range(0, ns);
      e = model(d, ng, nfft);
      lat = cfg_ok(d, ng, nfft) ? 3 * ns + 2 * ng : 1;
      run(d, ng, nfft, e, lat, $sformatf("rnd%0d_d%0d_g%0d_f%0d", t, d, ng, nfft));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
